// File: rtl/prng_pkg.sv
// Shared definitions for the bounded-draw PRNG: draw FSM states and the
// Galois feedback masks for each supported LFSR length.
package prng_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DRAW,
        ST_DONE
    } state_e;

    // Masks are maximal-length for the right-shifting Galois form.
    function automatic logic [31:0] taps_for(input int unsigned width);
        case (width)
            8:       taps_for = 32'h0000_00B8;
            16:      taps_for = 32'h0000_B400;
            24:      taps_for = 32'h00E1_0000;
            default: taps_for = 32'hA300_0000;
        endcase
    endfunction

endpackage

// File: rtl/prng_lfsr.sv
// Galois LFSR state register with step, seed load and all-zero lockout guard.
// Only the low OUT_W bits leave the module as the draw candidate.
module prng_lfsr
    import prng_pkg::*;
#(
    parameter int                OUT_W  = 5,
    parameter int                LFSR_W = 16,
    parameter logic [LFSR_W-1:0] SEED_V = 16'hACE1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              step_i,
    input  logic              load_i,
    input  logic [LFSR_W-1:0] seed_i,
    output logic [OUT_W-1:0]  cand_o
);

    localparam logic [31:0]       TAPS_FULL = taps_for(LFSR_W);
    localparam logic [LFSR_W-1:0] TAPS      = TAPS_FULL[LFSR_W-1:0];

    logic [LFSR_W-1:0] state_q;
    logic [LFSR_W-1:0] state_d;

    // A zero seed would lock the register at zero forever, so it maps to SEED_V.
    always_comb begin
        state_d = state_q;
        if (load_i) begin
            state_d = (seed_i == '0) ? SEED_V : seed_i;
        end else if (step_i) begin
            state_d = (state_q >> 1) ^ (state_q[0] ? TAPS : '0);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= SEED_V;
        end else begin
            state_q <= state_d;
        end
    end

    assign cand_o = state_q[OUT_W-1:0];

endmodule

// File: rtl/prng_gen.sv
// Bounded random draw generator: rejection-samples LFSR candidates against
// range_max, falling back to a masked candidate after MAX_TRIES attempts.
module prng_gen
    import prng_pkg::*;
#(
    parameter int          OUT_W     = 5,
    parameter int          LFSR_W    = 16,
    parameter logic [31:0] SEED      = 32'h0000_ACE1,
    parameter int          MAX_TRIES = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              seed_load,
    input  logic [LFSR_W-1:0] seed_in,
    input  logic [OUT_W-1:0]  range_max,
    input  logic              req,
    output logic [OUT_W-1:0]  rnd,
    output logic              rnd_valid,
    output logic              busy
);

    localparam logic [LFSR_W-1:0] SEED_W    = SEED[LFSR_W-1:0];
    localparam logic [7:0]        LAST_TRY  = 8'(MAX_TRIES - 1);

    state_e             state_q;
    logic [7:0]         try_q;
    logic [OUT_W-1:0]   rnd_q;
    logic               valid_q;
    logic               busy_q;
    logic [OUT_W-1:0]   candidate;
    logic               step;
    logic               accept;

    assign step   = (state_q == ST_DRAW) || ((state_q == ST_IDLE) && en);
    assign accept = (range_max == '0) || (candidate <= range_max);

    prng_lfsr #(
        .OUT_W  (OUT_W),
        .LFSR_W (LFSR_W),
        .SEED_V (SEED_W)
    ) u_lfsr (
        .clk    (clk),
        .rst    (rst),
        .step_i (step),
        .load_i (seed_load),
        .seed_i (seed_in),
        .cand_o (candidate)
    );

    // rnd_valid fires on the edge leaving DONE, so a single-attempt draw
    // reports two edges after the request was sampled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            try_q   <= '0;
            rnd_q   <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (req) begin
                        state_q <= ST_DRAW;
                        try_q   <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                ST_DRAW: begin
                    if (accept) begin
                        rnd_q   <= candidate;
                        state_q <= ST_DONE;
                    end else if (try_q == LAST_TRY) begin
                        rnd_q   <= candidate & range_max;
                        state_q <= ST_DONE;
                    end else begin
                        try_q <= try_q + 8'd1;
                    end
                end
                ST_DONE: begin
                    valid_q <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign rnd       = rnd_q;
    assign rnd_valid = valid_q;
    assign busy      = busy_q;

endmodule
